branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/PC width; legal values 32 and 64.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset: synchronous, active-low.
REQ-004 in_valid  in  1  upstream request valid.
REQ-005 in_ready  out  1  unit can accept a request this cycle.
REQ-006 in_instr  in  32  full instruction word.
REQ-007 in_pc  in  XLEN  PC of in_instr.
REQ-008 in_rs1_val, in_rs2_val  in  XLEN each  register operand values.
REQ-009 in_pred_taken  in  1  front-end prediction for this instruction.
REQ-010 flush  in  1  kill all in-flight requests.
REQ-011 out_valid  out  1  result valid; out_ready  in  1  downstream accepts.
REQ-012 out_pc, out_target, out_link  out  XLEN each  instruction PC, resolved next PC, return address.
REQ-013 out_taken, out_mispredict, out_misaligned, out_illegal  out  1 each  result flags.

Function
REQ-014 Two-stage pipeline: S1 decodes and registers fields; S2 compares, adds, registers result; latency exactly 2 cycles from accepted input to out_valid with no stall.
REQ-015 Transfer on valid&&ready at each boundary; stage advances when empty or next stage advancing; in_ready = !S1_valid || S1 advancing (combinational through both stages, no bubble at full throughput).
REQ-016 Outputs held stable while out_valid && !out_ready; no request dropped, duplicated or reordered.
REQ-017 B-type decode (opcode 1100011): rs1=instr[19:15], rs2=instr[24:20], imm13={instr[31],instr[7],instr[30:25],instr[11:8],1'b0}, sign-extended to XLEN; branch_control=instr[14:12].
REQ-018 Conditions: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 raise out_illegal, out_taken=0.
REQ-019 out_target = taken ? in_pc+imm : in_pc+4, modulo 2^XLEN (wrap-around, no overflow flag).
REQ-020 out_misaligned=1 when taken and out_target[1:0]!=0; out_target still reported.
REQ-021 out_mispredict = out_taken XOR in_pred_taken; forced 0 when out_illegal.
REQ-022 Any opcode not supported in the current configuration: out_illegal=1, out_taken=0, out_target=in_pc+4, out_link=0.
REQ-023 flush clears S1 and S2 valid next edge; input presented in the flush cycle is not accepted (in_ready=0 while flush=1); flush has priority over simultaneous advance.

Reset
REQ-024 rst_n low at a rising edge: S1/S2 valid cleared; out_valid=0, all other outputs 0; in_ready=1 the first cycle after reset released.
REQ-025 Reset mid-operation discards in-flight requests without emitting them.

Configuration
REQ-026 Macro BRANCH_JUMP_EN defined: JAL (1101111, imm21={instr[31],instr[19:12],instr[20],instr[30:21],0}) and JALR (1100111, funct3=000, target=(rs1+imm12)&~1) decode, out_taken=1, out_link=in_pc+4; JALR funct3!=000 illegal.
REQ-027 Macro undefined: JAL/JALR illegal per REQ-022; out_link constant 0; no jump logic synthesised.

Structure
REQ-028 Shared package holds opcode constants, branch_control enum (BEQ..BGEU), and the S1-to-S2 pipeline-register struct.
REQ-029 One sub-module, branch_cond_eval (combinational condition compare), instantiated in S2.

Verification
REQ-030 in_instr=0x00208463 (BEQ x1,x2,+8), pc=0x100, rs1=rs2=5, pred=0 -> 2 cycles later taken=1, target=0x108, mispredict=1.
REQ-031 BLT and BLTU with rs1=0xFFFFFFFF, rs2=1 -> BLT taken=1, BLTU taken=0, target=pc+4.
REQ-032 Three back-to-back requests, out_ready=0 for 3 cycles -> in_ready=0 after second held, all three emitted in order, outputs stable while stalled.
REQ-033 flush asserted with S1 and S2 full -> out_valid=0 next cycle, neither result ever emitted; funct3=010 -> illegal=1, mispredict=0.
REQ-034 pc=0xFFFFFFFC, taken imm=+8 -> target=0x00000004; with BRANCH_JUMP_EN, JALR rs1=0x1003 imm=0 -> target=0x1002, link=pc+4; rst_n low mid-stream -> out_valid=0 next cycle.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: shared opcode constants, branch_control enum
// and the S1-to-S2 pipeline-register bundle.
package branch_resolve_unit_pkg;

  localparam int XMAX = 64;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_ctrl_e;

  typedef enum logic [1:0] {
    K_BR,
    K_JAL,
    K_JALR,
    K_ILL
  } kind_e;

  // Fields sized for the widest XLEN; the unit uses the low XLEN bits.
  typedef struct packed {
    logic [XMAX-1:0] pc;
    logic [XMAX-1:0] rs1;
    logic [XMAX-1:0] rs2;
    logic [XMAX-1:0] imm;
    logic [2:0]      f3;
    kind_e           kind;
    logic            pred;
  } s1_s2_t;

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// branch_cond_eval: combinational B-type condition compare.
// Ports: a, b operands; f3 branch_control; taken result (0 for 010/011).
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      f3,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (f3)
      BEQ:     taken = (a == b);
      BNE:     taken = (a != b);
      BLT:     taken = ($signed(a) < $signed(b));
      BGE:     taken = ($signed(a) >= $signed(b));
      BLTU:    taken = (a < b);
      BGEU:    taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: 2-stage branch resolver (S1 decode, S2 resolve).
// Ports: in_* valid/ready request, flush, out_* valid/ready result; JAL/JALR via BRANCH_JUMP_EN.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic            in_pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic            out_misaligned,
  output logic            out_illegal
);

  logic   s1_valid;
  logic   s2_valid;
  logic   s2_adv;
  s1_s2_t s1d;
  s1_s2_t s1q;

  assign s2_adv   = !s2_valid || out_ready;
  assign in_ready = !flush && (!s1_valid || s2_adv);
  assign out_valid = s2_valid;

  // S1 decode
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_b;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31],
                  in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};

  // Register indices are not needed; values arrive pre-read.
  logic unused_idx;
  assign unused_idx = ^in_instr[24:15];

`ifdef BRANCH_JUMP_EN
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_i;

  assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31],
                  in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};
  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
`endif

  always_comb begin
    s1d      = '0;
    s1d.pc   = XMAX'(in_pc);
    s1d.rs1  = XMAX'(in_rs1_val);
    s1d.rs2  = XMAX'(in_rs2_val);
    s1d.imm  = XMAX'(imm_b);
    s1d.f3   = f3;
    s1d.pred = in_pred_taken;
    s1d.kind = K_ILL;
    unique case (1'b1)
      (opc == OP_BRANCH && f3[2:1] != 2'b01):
        s1d.kind = K_BR;
`ifdef BRANCH_JUMP_EN
      (opc == OP_JAL): begin
        s1d.kind = K_JAL;
        s1d.imm  = XMAX'(imm_j);
      end
      (opc == OP_JALR && f3 == 3'b000): begin
        s1d.kind = K_JALR;
        s1d.imm  = XMAX'(imm_i);
      end
`endif
      default: s1d.kind = K_ILL;
    endcase
  end

  // S2 resolve
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] seq;
  logic [XLEN-1:0] bt;
  logic [XLEN-1:0] tgt;
  logic            cond;
  logic            taken;
  logic            ill;
  logic            misal;
  logic            mp;

  assign pc  = s1q.pc[XLEN-1:0];
  assign rs1 = s1q.rs1[XLEN-1:0];
  assign rs2 = s1q.rs2[XLEN-1:0];
  assign imm = s1q.imm[XLEN-1:0];
  assign seq = pc + XLEN'(4);
  assign bt  = pc + imm;

  if (XLEN < XMAX) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^{s1q.pc[XMAX-1:XLEN],
                         s1q.rs1[XMAX-1:XLEN],
                         s1q.rs2[XMAX-1:XLEN],
                         s1q.imm[XMAX-1:XLEN]};
  end

  branch_cond_eval #(
    .XLEN (XLEN)
  ) u_cond (
    .a     (rs1),
    .b     (rs2),
    .f3    (s1q.f3),
    .taken (cond)
  );

`ifdef BRANCH_JUMP_EN
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] link_q;
`endif

  always_comb begin
    taken = 1'b0;
    ill   = 1'b0;
    tgt   = seq;
`ifdef BRANCH_JUMP_EN
    link  = '0;
`endif
    unique case (s1q.kind)
      K_BR: begin
        taken = cond;
        if (cond) tgt = bt;
      end
`ifdef BRANCH_JUMP_EN
      K_JAL: begin
        taken = 1'b1;
        tgt   = bt;
        link  = seq;
      end
      K_JALR: begin
        taken = 1'b1;
        tgt   = (rs1 + imm) & ~XLEN'(1);
        link  = seq;
      end
`endif
      default: ill = 1'b1;
    endcase
  end

  assign misal = taken && (tgt[1:0] != 2'b00);
  assign mp    = !ill && (taken ^ s1q.pred);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s2_valid       <= 1'b0;
      s1q            <= '0;
      out_pc         <= '0;
      out_target     <= '0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      out_misaligned <= 1'b0;
      out_illegal    <= 1'b0;
`ifdef BRANCH_JUMP_EN
      link_q         <= '0;
`endif
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_pc         <= pc;
          out_target     <= tgt;
          out_taken      <= taken;
          out_mispredict <= mp;
          out_misaligned <= misal;
          out_illegal    <= ill;
`ifdef BRANCH_JUMP_EN
          link_q         <= link;
`endif
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1q <= s1d;
      end
    end
  end

`ifdef BRANCH_JUMP_EN
  assign out_link = link_q;
`else
  assign out_link = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: vector table + scoreboard bench for
// branch_resolve_unit (XLEN=32), with stall, flush and reset sequences.
module tb_branch_resolve_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pred;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] link;
    logic        mp;
    logic        mis;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] link;
    logic        tk;
    logic        mp;
    logic        mis;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic        in_pred_taken;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_target;
  logic [31:0] out_link;
  logic        out_taken;
  logic        out_mispredict;
  logic        out_misaligned;
  logic        out_illegal;

  branch_resolve_unit #(
    .XLEN (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .in_rs1_val     (in_rs1_val),
    .in_rs2_val     (in_rs2_val),
    .in_pred_taken  (in_pred_taken),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_target     (out_target),
    .out_link       (out_link),
    .out_taken      (out_taken),
    .out_mispredict (out_mispredict),
    .out_misaligned (out_misaligned),
    .out_illegal    (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  vec_t vt[$];
  int   cmp = 0;
  int   bad = 0;

  function automatic logic [31:0] enc_b(input logic [2:0] f3,
                                        input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3,
            imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic vec_t mk(
    input logic [31:0] instr, input logic [31:0] pc,
    input logic [31:0] rs1, input logic [31:0] rs2,
    input logic pred, input logic tk,
    input logic [31:0] tgt, input logic [31:0] link,
    input logic mp, input logic mis, input logic ill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.pred = pred; v.tk = tk; v.tgt = tgt; v.link = link;
    v.mp = mp; v.mis = mis; v.ill = ill;
    return v;
  endfunction

  function automatic exp_t exp_of(input vec_t v);
    exp_t e;
    e.pc = v.pc; e.tgt = v.tgt; e.link = v.link;
    e.tk = v.tk; e.mp = v.mp; e.mis = v.mis; e.ill = v.ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    cmp++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Scoreboard: a transfer happens at the next rising edge when
  // valid&&ready holds; sample mid-low-phase after inputs settle.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && !flush && out_valid && out_ready) begin
      cmp++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got pc %h want no output", out_pc);
      end else begin
        e = q.pop_front();
        if ({out_pc, out_target, out_link, out_taken, out_mispredict,
             out_misaligned, out_illegal} !==
            {e.pc, e.tgt, e.link, e.tk, e.mp, e.mis, e.ill}) begin
          bad++;
          $display("FAIL result pc=%h: got tgt %h link %h t%b m%b a%b i%b want tgt %h link %h t%b m%b a%b i%b",
                   e.pc, out_target, out_link, out_taken, out_mispredict,
                   out_misaligned, out_illegal, e.tgt, e.link, e.tk,
                   e.mp, e.mis, e.ill);
        end
      end
    end
  end

  // Entered and returned at a falling edge; leaves in_valid high.
  task automatic send(input vec_t v);
    bit done;
    done = 1'b0;
    in_instr      = v.instr;
    in_pc         = v.pc;
    in_rs1_val    = v.rs1;
    in_rs2_val    = v.rs2;
    in_pred_taken = v.pred;
    in_valid      = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      if (in_ready) begin
        q.push_back(exp_of(v));
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      cmp++;
      bad++;
      $display("FAIL accept_timeout: got in_ready 0 want 1 (pc %h)", v.pc);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && q.size() != 0; n++) @(negedge clk);
    chk("drain_queue", 32'(q.size()), 32'd0);
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0;
    in_pred_taken = 1'b0;

    vt.push_back(mk(32'h00208463, 32'h100, 32'd5, 32'd5, 0,
                    1, 32'h108, 32'h0, 1, 0, 0));
    vt.push_back(mk(enc_b(3'b000, 13'd8), 32'h100, 32'd5, 32'd6, 0,
                    0, 32'h104, 32'h0, 0, 0, 0));
    vt.push_back(mk(enc_b(3'b001, 13'd8), 32'h200, 32'd5, 32'd6, 1,
                    1, 32'h208, 32'h0, 0, 0, 0));
    vt.push_back(mk(enc_b(3'b100, 13'd16), 32'h300, 32'hFFFFFFFF, 32'd1, 0,
                    1, 32'h310, 32'h0, 1, 0, 0));
    vt.push_back(mk(enc_b(3'b110, 13'd16), 32'h300, 32'hFFFFFFFF, 32'd1, 0,
                    0, 32'h304, 32'h0, 0, 0, 0));
    vt.push_back(mk(enc_b(3'b101, 13'h1FF8), 32'h400, 32'd1, 32'hFFFFFFFF, 1,
                    1, 32'h3F8, 32'h0, 0, 0, 0));
    vt.push_back(mk(enc_b(3'b111, 13'h1FF8), 32'h400, 32'd1, 32'hFFFFFFFF, 1,
                    0, 32'h404, 32'h0, 1, 0, 0));
    vt.push_back(mk(enc_b(3'b010, 13'd8), 32'h500, 32'd5, 32'd5, 1,
                    0, 32'h504, 32'h0, 0, 0, 1));
    vt.push_back(mk(enc_b(3'b011, 13'd8), 32'h600, 32'd5, 32'd5, 0,
                    0, 32'h604, 32'h0, 0, 0, 1));
    vt.push_back(mk(enc_b(3'b000, 13'd8), 32'hFFFFFFFC, 32'd0, 32'd0, 1,
                    1, 32'h4, 32'h0, 0, 0, 0));
    vt.push_back(mk(enc_b(3'b000, 13'd6), 32'h100, 32'd7, 32'd7, 1,
                    1, 32'h106, 32'h0, 0, 1, 0));
    vt.push_back(mk(enc_b(3'b001, 13'd6), 32'h100, 32'd7, 32'd7, 1,
                    0, 32'h104, 32'h0, 1, 0, 0));
    vt.push_back(mk(32'h00000013, 32'h700, 32'd0, 32'd0, 1,
                    0, 32'h704, 32'h0, 0, 0, 1));
`ifdef BRANCH_JUMP_EN
    vt.push_back(mk(32'h008000EF, 32'h800, 32'd0, 32'd0, 0,
                    1, 32'h808, 32'h804, 1, 0, 0));
    vt.push_back(mk(32'h000100E7, 32'h900, 32'h1003, 32'd0, 1,
                    1, 32'h1002, 32'h904, 0, 1, 0));
`else
    vt.push_back(mk(32'h008000EF, 32'h800, 32'd0, 32'd0, 0,
                    0, 32'h804, 32'h0, 0, 0, 1));
    vt.push_back(mk(32'h000100E7, 32'h900, 32'h1003, 32'd0, 1,
                    0, 32'h904, 32'h0, 0, 0, 1));
`endif
    vt.push_back(mk(32'h000110E7, 32'h900, 32'h1003, 32'd0, 1,
                    0, 32'h904, 32'h0, 0, 0, 1));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_target", out_target, 32'h0);
    chk("rst_flags", 32'({out_taken, out_mispredict,
                         out_misaligned, out_illegal}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Latency on the first vector
    send(vt[0]);
    in_valid = 1'b0;
    chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
    drain();

    // Full-throughput table
    for (int i = 1; i < vt.size(); i++) send(vt[i]);
    in_valid = 1'b0;
    drain();

    // Stall: three back-to-back, out_ready low
    out_ready = 1'b0;
    send(vt[0]);
    send(vt[3]);
    in_instr = vt[4].instr; in_pc = vt[4].pc;
    in_rs1_val = vt[4].rs1; in_rs2_val = vt[4].rs2;
    in_pred_taken = vt[4].pred; in_valid = 1'b1;
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pc", out_pc, vt[0].pc);
      chk("stall_target", out_target, vt[0].tgt);
    end
    out_ready = 1'b1;
    send(vt[4]);
    in_valid = 1'b0;
    drain();

    // Flush with S1 and S2 full
    out_ready = 1'b0;
    send(vt[1]);
    send(vt[2]);
    chk("pre_flush_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    in_instr = vt[5].instr; in_pc = vt[5].pc;
    in_rs1_val = vt[5].rs1; in_rs2_val = vt[5].rs2;
    in_pred_taken = vt[5].pred; in_valid = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    void'(q.pop_back());
    void'(q.pop_back());
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_flush_valid", 32'(out_valid), 32'd0);

    // Reset mid-stream
    out_ready = 1'b0;
    send(vt[6]);
    send(vt[7]);
    rst_n = 1'b0;
    in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_target", out_target, 32'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("midrst_no_emit", 32'(out_valid), 32'd0);

    // Traffic still flows after reset
    send(vt[9]);
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
